// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding and hazard unit for the decode stage.
// Tracks in-flight register writes in a DEPTH-entry shift register.
// Entry 0 is EX and entry DEPTH-1 is WB.
// Supplies bypassed operands for NUM_RD read ports.
// Raises a one-bubble load-use stall when a load in EX feeds a used operand.
// A saturating counter records the number of stalled cycles.
module fwd_scoreboard #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     issue_valid,
    input  logic                     issue_we,
    input  logic [REG_AW-1:0]        issue_rd,
    input  logic                     issue_is_load,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_used,
    input  logic [NUM_RD*DATA_W-1:0] rf_data,
    input  logic [DEPTH*DATA_W-1:0]  stage_data,
    output logic [NUM_RD*DATA_W-1:0] fwd_data,
    output logic [NUM_RD-1:0]        fwd_hit,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Scoreboard state: one {valid, we, rd, is_load} tuple per tracked stage.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  we_q, we_d;
    logic [DEPTH-1:0]  load_q, load_d;
    logic [REG_AW-1:0] rd_q [DEPTH];
    logic [REG_AW-1:0] rd_d [DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0]         writing_s;
    logic [NUM_RD*DATA_W-1:0] fwd_data_s;
    logic [NUM_RD-1:0]        fwd_hit_s;
    logic                     stall_s;

    // An entry produces a value only if it is valid and writes a non-zero register.
    always_comb begin
        writing_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && we_q[i] && (rd_q[i] != {REG_AW{1'b0}})) begin
                writing_s[i] = 1'b1;
            end else begin
                writing_s[i] = 1'b0;
            end
        end
    end

    // Per-port youngest-match select.
    // A load still in EX cannot be bypassed and stalls a used port.
    always_comb begin : bypass_comb
        logic [REG_AW-1:0] src;
        logic              found;
        logic              pending;
        logic [DATA_W-1:0] sel_data;
        fwd_data_s = rf_data;
        fwd_hit_s  = '0;
        stall_s    = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            src      = rd_addr[k*REG_AW +: REG_AW];
            found    = 1'b0;
            pending  = 1'b0;
            sel_data = rf_data[k*DATA_W +: DATA_W];
            // Walk from oldest to youngest so the lowest matching index wins.
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (writing_s[i] && (rd_q[i] == src)) begin
                    found    = 1'b1;
                    pending  = load_q[i] && (i == 0);
                    sel_data = stage_data[i*DATA_W +: DATA_W];
                end else begin
                    found    = found;
                    pending  = pending;
                    sel_data = sel_data;
                end
            end
            if (found && !pending) begin
                fwd_hit_s[k]                  = 1'b1;
                fwd_data_s[k*DATA_W +: DATA_W] = sel_data;
            end else if (pending && rd_used[k]) begin
                stall_s = 1'b1;
            end else begin
                fwd_hit_s[k] = 1'b0;
            end
        end
    end

    // Next scoreboard state: shift toward WB.
    // Entry 0 takes the issuing instruction unless stalled, otherwise a bubble.
    // The stall counter saturates at all-ones.
    always_comb begin
        valid_d[0] = issue_valid && !stall_s;
        we_d[0]    = issue_we;
        rd_d[0]    = issue_rd;
        load_d[0]  = issue_is_load;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            we_d[i]    = we_q[i-1];
            rd_d[i]    = rd_q[i-1];
            load_d[i]  = load_q[i-1];
        end
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers.
    // A synchronous reset empties the scoreboard and clears the counter, dropping any same-edge issue.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            valid_q     <= '0;
            we_q        <= '0;
            load_q      <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            we_q        <= we_d;
            load_q      <= load_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= rd_d[i];
            end
        end
    end

    assign fwd_data  = fwd_data_s;
    assign fwd_hit   = fwd_hit_s;
    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed testbench for fwd_scoreboard.
// The driver pushes hand-computed expectations into a queue.
// A negedge monitor pops each expectation and compares it with the DUT outputs.
module tb_fwd_scoreboard;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 2;

    logic                     CLOCK = 1'b0;
    logic                     RESET;
    logic                     issue_valid;
    logic                     issue_we;
    logic [REG_AW-1:0]        issue_rd;
    logic                     issue_is_load;
    logic [NUM_RD*REG_AW-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_used;
    logic [NUM_RD*DATA_W-1:0] rf_data;
    logic [DEPTH*DATA_W-1:0]  stage_data;
    logic [NUM_RD*DATA_W-1:0] fwd_data;
    logic [NUM_RD-1:0]        fwd_hit;
    logic                     stall;
    logic [CNT_W-1:0]         stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [31:0] fd1;
        logic [31:0] fd0;
        logic [1:0]  fh;
        logic        st;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    fwd_scoreboard #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_RD(NUM_RD),
        .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .issue_is_load(issue_is_load),
        .rd_addr(rd_addr), .rd_used(rd_used),
        .rf_data(rf_data), .stage_data(stage_data),
        .fwd_data(fwd_data), .fwd_hit(fwd_hit),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_out(input string name, input logic [31:0] fd1, input logic [31:0] fd0,
                              input logic [1:0] fh, input logic st, input logic [1:0] cnt);
        exp_t e;
        e.name = name; e.fd1 = fd1; e.fd0 = fd0; e.fh = fh; e.st = st; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_src(input int k, input logic [REG_AW-1:0] a);
        rd_addr[k*REG_AW +: REG_AW] = a;
    endtask

    task automatic set_stage(input logic [31:0] s2, input logic [31:0] s1, input logic [31:0] s0);
        stage_data = {s2, s1, s0};
    endtask

    task automatic issue(input logic v, input logic [REG_AW-1:0] rd, input logic ld);
        issue_valid   = v;
        issue_we      = 1'b1;
        issue_rd      = rd;
        issue_is_load = ld;
    endtask

    task automatic drain(input int n);
        issue_valid = 1'b0;
        rd_used     = 2'b00;
        rd_addr     = '0;
        for (int j = 0; j < n; j++) step();
    endtask

    // Monitor: compare each queued expectation against the outputs away from the active edge.
    always @(negedge CLOCK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (fwd_data !== {e.fd1, e.fd0}) begin
                tests_failed++;
                $display("FAIL %s fwd_data got=%h exp=%h", e.name, fwd_data, {e.fd1, e.fd0});
            end
            tests_run++;
            if (fwd_hit !== e.fh) begin
                tests_failed++;
                $display("FAIL %s fwd_hit got=%b exp=%b", e.name, fwd_hit, e.fh);
            end
            tests_run++;
            if (stall !== e.st) begin
                tests_failed++;
                $display("FAIL %s stall got=%b exp=%b", e.name, stall, e.st);
            end
            tests_run++;
            if (stall_cnt !== e.cnt) begin
                tests_failed++;
                $display("FAIL %s stall_cnt got=%0d exp=%0d", e.name, stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        RESET = 1'b1;
        issue(1'b0, 5'd0, 1'b0);
        rd_addr = '0;
        rd_used = '0;
        rf_data = {32'h0000_2222, 32'h0000_0011};
        set_stage(32'h0, 32'h0, 32'h0);
        step();
        step();
        RESET = 1'b0;

        // Reset state: no bypass, no stall, counter zero.
        set_src(0, 5'd5); set_src(1, 5'd0); rd_used = 2'b01;
        expect_out("reset", 32'h2222, 32'h11, 2'b00, 1'b0, 2'd0);

        // EX bypass of a non-load.
        issue(1'b1, 5'd8, 1'b0);
        step();
        issue_valid = 1'b0;
        set_src(0, 5'd0); set_src(1, 5'd8); rd_used = 2'b10;
        set_stage(32'h0, 32'h0, 32'hA5);
        expect_out("ex_bypass", 32'hA5, 32'h11, 2'b10, 1'b0, 2'd0);
        step();
        drain(3);

        // Load-use: one-cycle stall; the consumer is not recorded while stalled.
        issue(1'b1, 5'd9, 1'b1);
        step();
        issue(1'b1, 5'd10, 1'b0);
        set_src(0, 5'd9); set_src(1, 5'd10); rd_used = 2'b01;
        set_stage(32'h0, 32'h99, 32'h0);
        expect_out("load_use_stall", 32'h2222, 32'h11, 2'b00, 1'b1, 2'd0);
        step();
        expect_out("load_use_resolve", 32'h2222, 32'h99, 2'b01, 1'b0, 2'd1);
        step();
        issue_valid = 1'b0;
        set_stage(32'h77, 32'h99, 32'h55);
        expect_out("consumer_issued", 32'h55, 32'h77, 2'b11, 1'b0, 2'd1);
        step();
        drain(3);

        // Youngest match wins; rd=0 is never a producer.
        issue(1'b1, 5'd3, 1'b0);
        step();
        step();
        issue_valid = 1'b0;
        set_src(0, 5'd3); set_src(1, 5'd0); rd_used = 2'b01;
        set_stage(32'h0, 32'h11, 32'h22);
        expect_out("youngest_wins", 32'h2222, 32'h22, 2'b01, 1'b0, 2'd1);
        issue(1'b1, 5'd0, 1'b0);
        step();
        issue_valid = 1'b0;
        set_src(0, 5'd0); set_src(1, 5'd3); rd_used = 2'b11;
        set_stage(32'h66, 32'h44, 32'h33);
        expect_out("zero_reg", 32'h44, 32'h11, 2'b10, 1'b0, 2'd1);
        step();
        drain(3);

        // Aging through EX, MEM, WB, then back to the register file.
        issue(1'b1, 5'd7, 1'b0);
        step();
        issue_valid = 1'b0;
        set_src(0, 5'd7); set_src(1, 5'd0); rd_used = 2'b01;
        set_stage(32'h300, 32'h200, 32'h100);
        expect_out("age_ex", 32'h2222, 32'h100, 2'b01, 1'b0, 2'd1);
        step();
        expect_out("age_mem", 32'h2222, 32'h200, 2'b01, 1'b0, 2'd1);
        step();
        expect_out("age_wb", 32'h2222, 32'h300, 2'b01, 1'b0, 2'd1);
        step();
        expect_out("age_rf", 32'h2222, 32'h11, 2'b00, 1'b0, 2'd1);
        step();
        drain(1);

        // An unused port never stalls, but still reports bypass data.
        issue(1'b1, 5'd4, 1'b1);
        step();
        issue_valid = 1'b0;
        set_src(0, 5'd4); set_src(1, 5'd4); rd_used = 2'b00;
        expect_out("unused_no_stall", 32'h2222, 32'h11, 2'b00, 1'b0, 2'd1);
        step();
        expect_out("unused_mem_hit", 32'h200, 32'h200, 2'b11, 1'b0, 2'd1);
        step();
        drain(2);

        // Reset mid-operation discards a pending stall and drops the same-edge issue.
        issue(1'b1, 5'd4, 1'b1);
        step();
        issue(1'b1, 5'd12, 1'b0);
        set_src(0, 5'd4); set_src(1, 5'd0); rd_used = 2'b01;
        expect_out("pre_reset_stall", 32'h2222, 32'h11, 2'b00, 1'b1, 2'd1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        set_src(1, 5'd12);
        expect_out("reset_mid_op", 32'h2222, 32'h11, 2'b00, 1'b0, 2'd0);
        step();

        // Saturation: back-to-back load-use pairs give five stalls; a 2-bit counter stops at 3.
        issue(1'b1, 5'd4, 1'b1);
        set_src(0, 5'd4); set_src(1, 5'd0); rd_used = 2'b01;
        set_stage(32'h0, 32'h200, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            expect_out("sat_stall", 32'h2222, 32'h11, 2'b00, 1'b1, 2'((i > 3) ? 3 : i));
            step();
            expect_out("sat_release", 32'h2222, 32'h200, 2'b01, 1'b0, 2'((i + 1 > 3) ? 3 : i + 1));
            step();
        end

        drain(1);
        @(negedge CLOCK);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL queue_drain remaining=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
